// File: rtl/seven_segment_capture.sv
// Readback monitor for a multiplexed 4-digit seven-segment display.
// Recovers MM:SS from the anode/segment lines and emits binary minutes/seconds.
module seven_segment_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] anode_signals,
    input  logic [6:0] display_out,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       frame_valid,
    output logic       decode_error,
    output logic       stale
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]    anode_q, anode_prev_q;
    logic [6:0]    seg_q, seg_prev_q;
    logic [SW-1:0] settle_q, settle_d;
    logic          done_q, done_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic [6:0]    minutes_q, minutes_d, seconds_q, seconds_d;
    logic          frame_q, frame_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic       active, stable, accept, legal;
    logic [1:0] idx;
    logic [4:0] dec;

    // Returns {legal, bcd} for an active-low g..a pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: return 5'b1_0000;
            7'b1111001: return 5'b1_0001;
            7'b0100100: return 5'b1_0010;
            7'b0110000: return 5'b1_0011;
            7'b0011001: return 5'b1_0100;
            7'b0010010: return 5'b1_0101;
            7'b0000010: return 5'b1_0110;
            7'b1111000: return 5'b1_0111;
            7'b0000000: return 5'b1_1000;
            7'b0010000: return 5'b1_1001;
            default:    return 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        settle_d  = settle_q;
        done_d    = done_q;
        mask_d    = mask_q;
        digit_d   = digit_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = tmo_q;
        active    = 1'b1;
        idx       = 2'd0;

        case (anode_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: active = 1'b0;
        endcase

        stable = (anode_q == anode_prev_q) && (seg_q == seg_prev_q);
        dec    = decode_seg(seg_q);
        legal  = dec[4] && !(idx == 2'd1 && dec[3:0] > 4'd5);

        if (!active || !stable) begin
            settle_d = '0;
        end else if (settle_q != SETTLE_LAST) begin
            settle_d = settle_q + SW'(1);
        end

        // A new anode value opens a fresh acceptance window.
        if (!active || anode_q != anode_prev_q) begin
            done_d = 1'b0;
        end

        accept = active && stable && (settle_q == SETTLE_LAST) && !done_q;

        if (accept) begin
            done_d = 1'b1;
            if (legal) begin
                digit_d[idx] = dec[3:0];
                mask_d[idx]  = 1'b1;
                if (mask_d == 4'b1111) begin
                    frame_d   = 1'b1;
                    mask_d    = 4'b0000;
                    minutes_d = {3'b000, digit_d[3]} * 7'd10 + {3'b000, digit_d[2]};
                    seconds_d = {3'b000, digit_d[1]} * 7'd10 + {3'b000, digit_d[0]};
                end
            end else begin
                err_d       = 1'b1;
                mask_d[idx] = 1'b0;
            end
        end

        if (frame_d) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            anode_q      <= '0;
            anode_prev_q <= '0;
            seg_q        <= '0;
            seg_prev_q   <= '0;
            settle_q     <= '0;
            done_q       <= 1'b0;
            mask_q       <= '0;
            digit_q      <= '{default: '0};
            minutes_q    <= '0;
            seconds_q    <= '0;
            frame_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            anode_q      <= anode_signals;
            anode_prev_q <= anode_q;
            seg_q        <= display_out;
            seg_prev_q   <= seg_q;
            settle_q     <= settle_d;
            done_q       <= done_d;
            mask_q       <= mask_d;
            digit_q      <= digit_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            frame_q      <= frame_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign minutes      = minutes_q;
    assign seconds      = seconds_q;
    assign frame_valid  = frame_q;
    assign decode_error = err_q;
    assign stale        = (tmo_q == TIMEOUT_MAX);
endmodule
